// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed multiply (radix-2 Booth) / divide (restoring) for MULT/DIV.
// Latency: WIDTH+2 cycles from accepted start to done; divide-by-zero finishes in 1 cycle.
// Backpressure: start is only sampled in IDLE or DONE; while busy the requester must hold off.
//
// Ports:
//   clock     rising-edge clock for all state
//   reset     synchronous, active-low
//   start     operation request (accepted in IDLE or DONE)
//   op        0 = signed multiply, 1 = signed divide
//   a, b      multiplicand/multiplier or dividend/divisor, latched on accept
//   busy      high while iterating (RUN) and packing the result (FIX)
//   done      one-cycle completion pulse
//   div_zero  set in DONE when the divide had b == 0, cleared on the next accept
//   hi, lo    mult: product upper/lower half; div: remainder/quotient
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  // Control state
  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div_zero_q, div_zero_d;

  // Shared datapath.
  //   Multiply: {acc_hi, acc_lo, qm1} is the Booth accumulator {P_hi, P_lo, q_-1};
  //             mcand holds the sign-extended multiplicand.
  //   Divide:   acc_hi is the partial remainder, acc_lo shifts the dividend magnitude
  //             out at the top while quotient bits enter at the bottom;
  //             mcand holds the divisor magnitude.
  // acc_hi and mcand are one bit wider than an operand so that the most negative
  // multiplicand can be subtracted and a magnitude of 2^(WIDTH-1) fits unsigned.
  logic [WIDTH:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH:0]   mcand_q, mcand_d;

  // Architectural results
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Operand magnitudes; the unsigned interpretation of -(-2^(WIDTH-1)) is exactly 2^(WIDTH-1).
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;

  // Booth step: add or subtract the multiplicand according to {q0, q_-1}.
  logic [WIDTH:0] booth_sum;

  always_comb begin
    booth_sum = acc_hi_q;
    case ({acc_lo_q[0], qm1_q})
      2'b01:   booth_sum = acc_hi_q + mcand_q;
      2'b10:   booth_sum = acc_hi_q - mcand_q;
      default: booth_sum = acc_hi_q;
    endcase
  end

  // Restoring division step: shift next dividend bit into the remainder and
  // subtract the divisor if it fits.
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] rem_diff;
  logic           rem_ge;

  assign rem_shift = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
  assign rem_diff  = rem_shift - mcand_q;
  assign rem_ge    = (rem_shift >= mcand_q);

  // Sign correction for the divide result. The remainder is always below the
  // divisor magnitude, so its top bit is zero and the low WIDTH bits carry it.
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  assign quot_fix = neg_quot_q ? -acc_lo_q : acc_lo_q;
  assign rem_fix  = neg_rem_q ? -acc_hi_q[WIDTH-1:0] : acc_hi_q[WIDTH-1:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    qm1_d      = qm1_q;
    mcand_d    = mcand_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    case (state_q)
      S_RUN: begin
        cnt_d = cnt_q + CNT_ONE;
        if (!op_q) begin
          // Arithmetic shift right of {booth_sum, acc_lo, qm1} by one.
          acc_hi_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
          acc_lo_d = {booth_sum[0], acc_lo_q[WIDTH-1:1]};
          qm1_d    = acc_lo_q[0];
        end else begin
          acc_hi_d = rem_ge ? rem_diff : rem_shift;
          acc_lo_d = {acc_lo_q[WIDTH-2:0], rem_ge};
        end
        if (cnt_q == LAST_ITER) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (!op_q) begin
          // Product is the low 2*WIDTH bits of the widened accumulator.
          hi_d = acc_hi_q[WIDTH-1:0];
          lo_d = acc_lo_q;
        end else begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end
        state_d = S_DONE;
      end

      default: begin
        // IDLE and DONE both accept a new request, which allows back-to-back issue.
        if (start) begin
          op_d       = op;
          div_zero_d = 1'b0;
          neg_quot_d = a[WIDTH-1] ^ b[WIDTH-1];
          neg_rem_d  = a[WIDTH-1];
          cnt_d      = '0;
          qm1_d      = 1'b0;
          acc_hi_d   = '0;
          if (!op) begin
            acc_lo_d = b;
            mcand_d  = {a[WIDTH-1], a};
            state_d  = S_RUN;
          end else if (b == '0) begin
            // No iterations; hi/lo keep the previous result.
            div_zero_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            acc_lo_d = a_mag;
            mcand_d  = {1'b0, b_mag};
            state_d  = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      qm1_q      <= 1'b0;
      mcand_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      qm1_q      <= qm1_d;
      mcand_q    <= mcand_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy     = (state_q == S_RUN) || (state_q == S_FIX);
  assign done     = (state_q == S_DONE);
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized and directed checks of mult_div_unit against a
// plain-arithmetic reference (64-bit signed product, truncating signed divide).
// Inputs are driven just after the rising edge, outputs sampled on the falling edge.
module tb_mult_div_unit;

  localparam int W = 32;
  localparam int LAT_RUN = W + 2;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference copy of the architectural {hi, lo}.
  logic [2*W-1:0] model_hilo = '0;

  always #5 clock = ~clock;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return p;
  endfunction

  // Returns {remainder, quotient}; SV integer division truncates toward zero
  // and the remainder takes the dividend's sign.
  function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] x, input logic [W-1:0] y);
    longint la, lb, q, r;
    la = longint'($signed(x));
    lb = longint'($signed(y));
    q = la / lb;
    r = la % lb;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  function automatic logic [W-1:0] rnd_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 6))
      0:       v = '0;
      1:       v = 32'h8000_0000;
      2:       v = 32'hFFFF_FFFF;
      3:       v = W'($urandom_range(1, 15));
      4:       v = -W'($urandom_range(1, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Expected outcome of one operation; also advances the reference hi/lo.
  task automatic model_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [2*W-1:0] eh, output logic edz, output int elat);
    if (o && (y == '0)) begin
      eh = model_hilo;
      edz = 1'b1;
      elat = 1;
    end else begin
      eh = o ? ref_div(x, y) : ref_mul(x, y);
      edz = 1'b0;
      elat = LAT_RUN;
    end
    model_hilo = eh;
  endtask

  // Starting from just after an accepting edge, count cycles until done (bounded).
  task automatic wait_done(output int lat, output int busy_cycles);
    lat = -1;
    busy_cycles = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clock);
      if (busy) busy_cycles++;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  // Issue one request from IDLE, scramble the inputs after acceptance, wait for done.
  task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [2*W-1:0] hilo, output logic dz,
                        output int lat, output int busy_cycles);
    @(posedge clock); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clock); #1;
    start = 1'b0; op = 1'($urandom); a = $urandom; b = $urandom;
    wait_done(lat, busy_cycles);
    hilo = {hi, lo};
    dz = div_zero;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    n_cmp++;
    if ({hi, lo} !== 64'h0) begin
      n_fail++; $display("FAIL reset_hilo: got %h expected %h", {hi, lo}, 64'h0);
    end
    n_cmp++;
    if ({busy, done, div_zero} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got busy/done/dz=%b expected 000", {busy, done, div_zero});
    end
  endtask

  task automatic test_mult();
    logic [W-1:0]   dx [2] = '{32'h0000_0007, 32'h8000_0000};
    logic [W-1:0]   dy [2] = '{32'hFFFF_FFFD, 32'h8000_0000};
    logic [2*W-1:0] dr [2] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'h4000_0000_0000_0000};
    logic [2*W-1:0] got, eh;
    logic dz, edz;
    int lat, bc, elat;
    for (int i = 0; i < 2; i++) begin
      run_op(1'b0, dx[i], dy[i], got, dz, lat, bc);
      model_hilo = dr[i];
      n_cmp++;
      if (got !== dr[i]) begin
        n_fail++; $display("FAIL mult_directed[%0d]: got %h expected %h", i, got, dr[i]);
      end
      n_cmp++;
      if (lat != LAT_RUN || bc != W + 1) begin
        n_fail++; $display("FAIL mult_timing[%0d]: got lat=%0d busy=%0d expected lat=%0d busy=%0d", i, lat, bc, LAT_RUN, W + 1);
      end
    end
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] x, y;
      x = rnd_operand();
      y = rnd_operand();
      run_op(1'b0, x, y, got, dz, lat, bc);
      model_op(1'b0, x, y, eh, edz, elat);
      n_cmp++;
      if (got !== eh || dz !== edz || lat != elat) begin
        n_fail++; $display("FAIL mult_rand %h*%h: got %h dz=%b lat=%0d expected %h dz=%b lat=%0d", x, y, got, dz, lat, eh, edz, elat);
      end
    end
  endtask

  task automatic test_div();
    logic [W-1:0]   dx [3] = '{32'hFFFF_FFF9, 32'h0000_0007, 32'h8000_0000};
    logic [W-1:0]   dy [3] = '{32'h0000_0002, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    logic [2*W-1:0] dr [3] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0001_FFFF_FFFD, 64'h0000_0000_8000_0000};
    logic [2*W-1:0] got, eh;
    logic dz, edz;
    int lat, bc, elat;
    for (int i = 0; i < 3; i++) begin
      run_op(1'b1, dx[i], dy[i], got, dz, lat, bc);
      model_hilo = dr[i];
      n_cmp++;
      if (got !== dr[i] || dz !== 1'b0) begin
        n_fail++; $display("FAIL div_directed[%0d]: got %h dz=%b expected %h dz=0", i, got, dz, dr[i]);
      end
      n_cmp++;
      if (lat != LAT_RUN || bc != W + 1) begin
        n_fail++; $display("FAIL div_timing[%0d]: got lat=%0d busy=%0d expected lat=%0d busy=%0d", i, lat, bc, LAT_RUN, W + 1);
      end
    end
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] x, y;
      x = rnd_operand();
      y = rnd_operand();
      run_op(1'b1, x, y, got, dz, lat, bc);
      model_op(1'b1, x, y, eh, edz, elat);
      n_cmp++;
      if (got !== eh || dz !== edz || lat != elat) begin
        n_fail++; $display("FAIL div_rand %h/%h: got %h dz=%b lat=%0d expected %h dz=%b lat=%0d", x, y, got, dz, lat, eh, edz, elat);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [2*W-1:0] got, eh, prior;
    logic dz, edz;
    int lat, bc, elat;
    run_op(1'b0, 32'h1234_5678, 32'hFEDC_BA98, got, dz, lat, bc);
    model_op(1'b0, 32'h1234_5678, 32'hFEDC_BA98, eh, edz, elat);
    prior = eh;
    run_op(1'b1, 32'd10, 32'd0, got, dz, lat, bc);
    model_op(1'b1, 32'd10, 32'd0, eh, edz, elat);
    n_cmp++;
    if (lat != 1 || bc != 0) begin
      n_fail++; $display("FAIL divzero_timing: got lat=%0d busy=%0d expected lat=1 busy=0", lat, bc);
    end
    n_cmp++;
    if (dz !== 1'b1) begin
      n_fail++; $display("FAIL divzero_flag: got %b expected 1", dz);
    end
    n_cmp++;
    if (got !== prior) begin
      n_fail++; $display("FAIL divzero_hilo_kept: got %h expected %h", got, prior);
    end
    run_op(1'b1, 32'd100, 32'd7, got, dz, lat, bc);
    model_op(1'b1, 32'd100, 32'd7, eh, edz, elat);
    n_cmp++;
    if (dz !== 1'b0 || got !== eh) begin
      n_fail++; $display("FAIL divzero_clear: got %h dz=%b expected %h dz=0", got, dz, eh);
    end
  endtask

  task automatic test_start_while_busy();
    logic [W-1:0] x, y;
    logic [2*W-1:0] eh;
    logic edz;
    int lat, elat;
    x = $urandom;
    y = $urandom | 32'h1;
    @(posedge clock); #1;
    start = 1'b1; op = 1'b1; a = x; b = y;
    @(posedge clock); #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clock);
      if (done) begin
        lat = n;
        break;
      end
      start = (n == 5 || n == 20);
      op = 1'($urandom); a = $urandom; b = $urandom;
    end
    start = 1'b0;
    model_op(1'b1, x, y, eh, edz, elat);
    n_cmp++;
    if (lat != elat || {hi, lo} !== eh) begin
      n_fail++; $display("FAIL start_ignored: got %h lat=%0d expected %h lat=%0d", {hi, lo}, lat, eh, elat);
    end
    @(negedge clock);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL done_one_cycle: got busy/done=%b expected 00", {busy, done});
    end
  endtask

  task automatic test_back_to_back();
    logic o;
    logic [W-1:0] x, y;
    logic [2*W-1:0] eh;
    logic edz;
    int lat, bc, elat;
    @(posedge clock); #1;
    for (int i = 0; i < 5; i++) begin
      o = 1'($urandom);
      x = rnd_operand();
      y = rnd_operand();
      if (i == 2) begin
        o = 1'b1;
        y = '0;
      end
      // From the second iteration on this is driven inside the DONE cycle.
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clock); #1;
      start = 1'b0;
      wait_done(lat, bc);
      model_op(o, x, y, eh, edz, elat);
      n_cmp++;
      if (lat != elat || {hi, lo} !== eh || div_zero !== edz) begin
        n_fail++; $display("FAIL back_to_back[%0d] op=%b %h,%h: got %h dz=%b lat=%0d expected %h dz=%b lat=%0d", i, o, x, y, {hi, lo}, div_zero, lat, eh, edz, elat);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [2*W-1:0] got, eh;
    logic dz, edz;
    int lat, bc, elat, pulses;
    run_op(1'b0, 32'h0BAD_F00D, 32'h8765_4321, got, dz, lat, bc);
    model_op(1'b0, 32'h0BAD_F00D, 32'h8765_4321, eh, edz, elat);
    n_cmp++;
    if (got !== eh) begin
      n_fail++; $display("FAIL pre_reset_mult: got %h expected %h", got, eh);
    end
    @(posedge clock); #1;
    start = 1'b1; op = 1'b0; a = 32'h7FFF_FFFF; b = 32'h7FFF_FFFF;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (16) @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    model_hilo = '0;
    @(negedge clock);
    n_cmp++;
    if ({busy, done, div_zero} !== 3'b000) begin
      n_fail++; $display("FAIL midreset_flags: got busy/done/dz=%b expected 000", {busy, done, div_zero});
    end
    n_cmp++;
    if ({hi, lo} !== 64'h0) begin
      n_fail++; $display("FAIL midreset_hilo: got %h expected %h", {hi, lo}, 64'h0);
    end
    pulses = 0;
    repeat (40) begin
      @(negedge clock);
      if (done || busy) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_fail++; $display("FAIL midreset_no_done: got %0d active cycles expected 0", pulses);
    end
    run_op(1'b0, 32'hFFFF_FFFF, 32'h8000_0000, got, dz, lat, bc);
    model_op(1'b0, 32'hFFFF_FFFF, 32'h8000_0000, eh, edz, elat);
    n_cmp++;
    if (got !== eh || lat != elat) begin
      n_fail++; $display("FAIL post_reset_mult: got %h lat=%0d expected %h lat=%0d", got, lat, eh, elat);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multicycle signed multiply/divide unit for MULT and DIV instructions.
- Sits downstream of the register bank: operands come from the register-bank read ports (A/B registers); results go to the HI/LO registers.
- Driven by unidade_controle through a start/busy/done handshake; the control FSM holds in a wait state while busy.
- Radix-2 Booth multiplier and restoring divider share one iteration counter and one FSM.

Parameters:
WIDTH, 32, operand width; hi/lo are each WIDTH bits; iteration count = WIDTH.

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset
start  in  1  request; sampled only in IDLE or DONE
op  in  1  0 = signed multiply, 1 = signed divide
a  in  WIDTH  multiplicand / dividend, latched on accepted start
b  in  WIDTH  multiplier / divisor, latched on accepted start
busy  out  1  high in RUN and FIX
done  out  1  one-cycle pulse, high only in DONE
div_zero  out  1  high in DONE when the divide had b == 0; cleared on the next accepted start
hi  out  WIDTH  mult: upper product half; div: remainder
lo  out  WIDTH  mult: lower product half; div: quotient

Behaviour:
- Reset (reset == 0 at a clock edge):
  - State goes to IDLE.
  - hi, lo = 0; busy, done, div_zero = 0; counter = 0.
  - Reset overrides everything, including mid-RUN: the partial result is discarded and hi/lo do not update.
- States: IDLE, RUN, FIX, DONE.
  - IDLE: on start, latch a, b, op; clear div_zero.
    - op = 0, or op = 1 with b != 0: go to RUN, counter = 0.
    - op = 1 with b == 0: go to DONE directly; div_zero = 1; hi/lo keep their previous values.
  - RUN: one iteration per cycle; counter increments.
    - After WIDTH iterations (counter == WIDTH-1 at the edge), go to FIX.
  - FIX: sign correction / result packing; load hi, lo; go to DONE.
  - DONE: done = 1 for exactly one cycle.
    - start high: accept it as in IDLE (back-to-back issue allowed).
    - start low: go to IDLE.
- Latency: start accepted at edge k → done high in the cycle following edge k+WIDTH+1 (WIDTH+2 cycles; 34 for WIDTH = 32). Divide-by-zero: done high after edge k (1 cycle).
- start during RUN/FIX is ignored; latched operands never change mid-operation.
- hi/lo hold the last result until the next FIX or reset; they are valid from DONE onward.
- Multiply:
  - Booth radix-2 on a 2*WIDTH+1-bit accumulator {P_hi, P_lo, q_-1}.
  - Each step adds/subtracts the multiplicand into the upper part per bits {q0, q_-1}, then arithmetic shift right by 1.
  - Result = full signed 2*WIDTH-bit product: hi = [2W-1:W], lo = [W-1:0]. No overflow possible.
- Divide:
  - Restoring division on operand magnitudes; signs recorded at start.
  - Quotient truncates toward zero.
  - Quotient negated if the signs of a and b differ; remainder takes the sign of the dividend.
  - Identity a == b*lo + hi with |hi| < |b|.
  - Overflow case a = 0x80000000, b = 0xFFFFFFFF: lo = 0x80000000, hi = 0 (wraps); div_zero = 0.
- All arithmetic is modulo 2^WIDTH per half. Magnitude of 0x80000000 is handled as unsigned 2^31 internally (WIDTH+1-bit datapath).

Test Plan:
1. Reset low 2 cycles, then high → hi = lo = 0, busy = done = div_zero = 0, state IDLE.
2. op=0, a=7, b=0xFFFFFFFD (−3), start 1 cycle → busy for 33 cycles; done pulse 34 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB. Also a=b=0x80000000 → hi=0x40000000, lo=0x00000000.
3. op=1, a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also a=7, b=0xFFFFFFFE → lo=0xFFFFFFFD, hi=1. Also a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
4. Divide by zero: with a prior result loaded, op=1, a=10, b=0 → next cycle done=1, div_zero=1, busy never high, hi/lo unchanged. A following good start clears div_zero.
5. Start while busy: start pulsed at cycles 5 and 20 of a run with different a/b → ignored; result matches the original operands. Start held high in the DONE cycle → new operation accepted; second done arrives 34 cycles later.
6. Reset mid-operation: reset low at iteration 16 of a multiply → next cycle IDLE, busy = 0, hi = lo = 0, no done pulse; a new start afterwards completes correctly.
